// File: rtl/cpu_arb_pkg.sv
// Shared state encoding, widths and helpers for the round-robin CPU arbiter.
package cpu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

  localparam int CHECK_CNT_W = 8;
  localparam int LAT_CNT_W   = 4;

  function automatic int idWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cpu_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping upward.
module rr_pick
  import cpu_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = idWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     idx_o,
  output logic               any_o
);

  logic found;

  // Requesters at or above the pointer take priority; the ones below it are the wrapped tail.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req_i[j] && (IDW'(j) >= ptr_i)) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDW'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req_i[j] && (IDW'(j) < ptr_i)) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDW'(j);
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/cpu_arbiter.sv
// Round-robin arbiter that time-shares one cpu core: accept one request, drive the core for
// CPU_LAT cycles, sample its outputs and return a one-cycle response to the winner.
module cpu_arbiter
  import cpu_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int CPU_LAT = 2,
  localparam int IDW     = idWidth(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic                   rsp_data,
  output logic                   rsp_check,
  output logic                   cpu_sig_i,
  input  logic                   cpu_sig_o,
  input  logic                   cpu_checker,
  output logic                   busy,
  output logic [IDW-1:0]         grant_id,
  output logic [CHECK_CNT_W-1:0] check_count
);

  arb_state_e             state_q;
  logic [IDW-1:0]         rrPtr_q, rrPtr_d;
  logic [IDW-1:0]         grantId_q;
  logic [LAT_CNT_W-1:0]   latCnt_q;
  logic                   bit_q;
  logic                   rspData_q;
  logic                   rspCheck_q;
  logic [CHECK_CNT_W-1:0] checkCount_q, checkCount_d;

  logic [NUM_REQ-1:0]     pickGrant;
  logic [IDW-1:0]         pickIdx;
  logic                   pickAny;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rrPtr_q),
    .grant_o (pickGrant),
    .idx_o   (pickIdx),
    .any_o   (pickAny)
  );

  // Pointer wrap and saturating counter next-states, plus the state-decoded strobes.
  always_comb begin
    rrPtr_d      = (pickIdx == IDW'(NUM_REQ - 1)) ? '0 : pickIdx + IDW'(1);
    checkCount_d = (rspCheck_q && (checkCount_q != '1)) ? checkCount_q + CHECK_CNT_W'(1)
                                                        : checkCount_q;
    req_ready    = (state_q == IDLE) ? pickGrant : '0;
    rsp_valid    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = (state_q == RESP) && (grantId_q == IDW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rrPtr_q      <= '0;
      grantId_q    <= '0;
      latCnt_q     <= '0;
      bit_q        <= 1'b0;
      rspData_q    <= 1'b0;
      rspCheck_q   <= 1'b0;
      checkCount_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pickAny) begin
            bit_q     <= req_data[pickIdx];
            grantId_q <= pickIdx;
            rrPtr_q   <= rrPtr_d;
            latCnt_q  <= LAT_CNT_W'(CPU_LAT - 1);
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          // The core's answer is valid in the last execution cycle.
          if (latCnt_q == '0) begin
            rspData_q  <= cpu_sig_o;
            rspCheck_q <= cpu_checker & cpu_sig_o;
            state_q    <= RESP;
          end else begin
            latCnt_q <= latCnt_q - LAT_CNT_W'(1);
          end
        end
        RESP: begin
          checkCount_q <= checkCount_d;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign cpu_sig_i   = (state_q == EXEC) && bit_q;
  assign rsp_data    = rspData_q;
  assign rsp_check   = rspCheck_q;
  assign grant_id    = grantId_q;
  assign check_count = checkCount_q;

endmodule

// File: tb/tb_cpu_arbiter.sv
// Bench for cpu_arbiter: a transaction-level model checks two configurations every cycle,
// while directed literal checks pin down the model on the key scenarios.
module tb_cpu_arbiter;

  localparam int NA = 4;
  localparam int LA = 2;
  localparam int NB = 1;
  localparam int LB = 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic [NA-1:0] reqValidA, reqDataA, reqReadyA, rspValidA;
  logic          rspDataA, rspCheckA, cpuSigIA, cpuSigOA, cpuCheckerA, busyA;
  logic [1:0]    grantIdA;
  logic [7:0]    checkCountA;

  logic [NB-1:0] reqValidB, reqDataB, reqReadyB, rspValidB;
  logic          rspDataB, rspCheckB, cpuSigIB, cpuSigOB, cpuCheckerB, busyB;
  logic [0:0]    grantIdB;
  logic [7:0]    checkCountB;

  cpu_arbiter #(.NUM_REQ(NA), .CPU_LAT(LA)) dutA (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (reqValidA),
    .req_data    (reqDataA),
    .req_ready   (reqReadyA),
    .rsp_valid   (rspValidA),
    .rsp_data    (rspDataA),
    .rsp_check   (rspCheckA),
    .cpu_sig_i   (cpuSigIA),
    .cpu_sig_o   (cpuSigOA),
    .cpu_checker (cpuCheckerA),
    .busy        (busyA),
    .grant_id    (grantIdA),
    .check_count (checkCountA)
  );

  cpu_arbiter #(.NUM_REQ(NB), .CPU_LAT(LB)) dutB (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (reqValidB),
    .req_data    (reqDataB),
    .req_ready   (reqReadyB),
    .rsp_valid   (rspValidB),
    .rsp_data    (rspDataB),
    .rsp_check   (rspCheckB),
    .cpu_sig_i   (cpuSigIB),
    .cpu_sig_o   (cpuSigOB),
    .cpu_checker (cpuCheckerB),
    .busy        (busyB),
    .grant_id    (grantIdB),
    .check_count (checkCountB)
  );

  // s is cycles since accept (-1 when idle); the rest are the values the spec says must be visible.
  typedef struct packed {
    int s;
    int ptr;
    int grant;
    bit b;
    bit rd;
    bit rc;
    int cnt;
  } model_t;

  model_t mA, mB, mAn, mBn;
  int     nPass    = 0;
  int     nChecks  = 0;
  int     coreMode = 0;

  function automatic model_t resetModel();
    model_t m;
    m     = '0;
    m.s   = -1;
    return m;
  endfunction

  function automatic int pickWinner(input int n, input int ptr, input logic [15:0] req);
    for (int k = 0; k < n; k++) begin
      if (req[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
  endtask

  // Compares one configuration against its model for the current cycle, then advances the model.
  task automatic modelStep(input string tag, input int n, input int lat,
                           input model_t mi, output model_t mo,
                           input logic [15:0] req, input logic [15:0] dat,
                           input logic sigO, input logic chk,
                           input logic [15:0] ready, input logic [15:0] rspV,
                           input logic rd, input logic rc, input logic sigI,
                           input logic bsy, input int gid, input int cnt);
    int          w;
    logic [15:0] expReady, expRsp;
    mo       = mi;
    w        = (mi.s < 0) ? pickWinner(n, mi.ptr, req) : -1;
    expReady = (w >= 0) ? (16'(1) << w) : 16'(0);
    expRsp   = (mi.s == lat + 1) ? (16'(1) << mi.grant) : 16'(0);
    checkOutput({tag, ".req_ready"}, int'(ready), int'(expReady));
    checkOutput({tag, ".rsp_valid"}, int'(rspV), int'(expRsp));
    checkOutput({tag, ".busy"}, int'(bsy), (mi.s >= 0) ? 1 : 0);
    checkOutput({tag, ".cpu_sig_i"}, int'(sigI), (mi.s >= 1 && mi.s <= lat) ? int'(mi.b) : 0);
    checkOutput({tag, ".grant_id"}, gid, mi.grant);
    checkOutput({tag, ".check_count"}, cnt, mi.cnt);
    if (mi.s == lat + 1) begin
      checkOutput({tag, ".rsp_data"}, int'(rd), int'(mi.rd));
      checkOutput({tag, ".rsp_check"}, int'(rc), int'(mi.rc));
    end
    if (rst) begin
      mo = resetModel();
    end else if (w >= 0) begin
      mo.grant = w;
      mo.b     = dat[w];
      mo.ptr   = (w + 1) % n;
      mo.s     = 1;
    end else if (mi.s >= 1 && mi.s <= lat) begin
      if (mi.s == lat) begin
        mo.rd = sigO;
        mo.rc = sigO & chk;
      end
      mo.s = mi.s + 1;
    end else if (mi.s == lat + 1) begin
      if (mi.rc && mi.cnt < 255) mo.cnt = mi.cnt + 1;
      mo.s = -1;
    end
  endtask

  // The compare process: every cycle, both configurations, away from the active edge.
  always @(negedge clk) begin
    modelStep("A", NA, LA, mA, mAn, 16'(reqValidA), 16'(reqDataA), cpuSigOA, cpuCheckerA,
              16'(reqReadyA), 16'(rspValidA), rspDataA, rspCheckA, cpuSigIA, busyA,
              int'(grantIdA), int'(checkCountA));
    mA = mAn;
    modelStep("B", NB, LB, mB, mBn, 16'(reqValidB), 16'(reqDataB), cpuSigOB, cpuCheckerB,
              16'(reqReadyB), 16'(rspValidB), rspDataB, rspCheckB, cpuSigIB, busyB,
              int'(grantIdB), int'(checkCountB));
    mB = mBn;
  end

  task automatic driveCore();
    case (coreMode)
      1: begin cpuSigOA = 1'b1; cpuCheckerA = 1'b1; cpuSigOB = 1'b1; cpuCheckerB = 1'b1; end
      2: begin cpuSigOA = 1'b0; cpuCheckerA = 1'b1; cpuSigOB = 1'b0; cpuCheckerB = 1'b1; end
      3: begin cpuSigOA = 1'b1; cpuCheckerA = 1'b0; cpuSigOB = 1'b1; cpuCheckerB = 1'b0; end
      default: begin
        cpuSigOA    = 1'($urandom_range(0, 1));
        cpuCheckerA = 1'($urandom_range(0, 1));
        cpuSigOB    = 1'($urandom_range(0, 1));
        cpuCheckerB = 1'($urandom_range(0, 1));
      end
    endcase
  endtask

  // Drives one cycle's inputs just after the edge and returns after that cycle has been compared.
  task automatic applyStimulus(input logic [3:0] vA, input logic [3:0] dA,
                               input logic vB, input logic dB, input logic r);
    @(posedge clk);
    #1;
    rst       = r;
    reqValidA = vA;
    reqDataA  = dA;
    reqValidB = vB;
    reqDataB  = dB;
    driveCore();
    @(negedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mA          = resetModel();
    mB          = resetModel();
    rst         = 1'b1;
    reqValidA   = '0;
    reqDataA    = '0;
    reqValidB   = '0;
    reqDataB    = '0;
    cpuSigOA    = 1'b0;
    cpuCheckerA = 1'b0;
    cpuSigOB    = 1'b0;
    cpuCheckerB = 1'b0;

    // Reset state.
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset.req_ready", int'(reqReadyA), 0);
    checkOutput("reset.rsp_valid", int'(rspValidA), 0);
    checkOutput("reset.busy", int'(busyA), 0);
    checkOutput("reset.cpu_sig_i", int'(cpuSigIA), 0);
    checkOutput("reset.grant_id", int'(grantIdA), 0);
    checkOutput("reset.check_count", int'(checkCountA), 0);
    idleCycles(1);

    // Single request from requester 0.
    coreMode = 3;
    applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
    checkOutput("single.req_ready", int'(reqReadyA), 1);
    for (int c = 1; c <= 2; c++) begin
      applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("single.cpu_sig_i", int'(cpuSigIA), 1);
      checkOutput("single.busy", int'(busyA), 1);
    end
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("single.rsp_valid", int'(rspValidA), 1);
    checkOutput("single.rsp_data", int'(rspDataA), 1);
    checkOutput("single.rsp_check", int'(rspCheckA), 0);
    checkOutput("single.busy_resp", int'(busyA), 1);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("single.busy_after", int'(busyA), 0);

    // Fairness with all requesters held high from a fresh pointer.
    coreMode = 0;
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    idleCycles(1);
    for (int c = 0; c < 20; c++) begin
      applyStimulus(4'hF, 4'($urandom), 1'b0, 1'b0, 1'b0);
      if (c % 4 == 0) checkOutput("fair.req_ready", int'(reqReadyA), 1 << ((c / 4) % 4));
      if (c % 4 == 1) checkOutput("fair.grant_id", int'(grantIdA), (c / 4) % 4);
      if (c % 4 == 3) checkOutput("fair.rsp_valid", int'(rspValidA), 1 << ((c / 4) % 4));
    end

    // Pointer: grant 2, then 1001 serves 3 before 0.
    applyStimulus(4'b0100, 4'($urandom), 1'b0, 1'b0, 1'b0);
    checkOutput("ptr.first", int'(reqReadyA), 4);
    idleCycles(3);
    applyStimulus(4'b1001, 4'($urandom), 1'b0, 1'b0, 1'b0);
    checkOutput("ptr.second", int'(reqReadyA), 8);
    repeat (3) applyStimulus(4'b1001, 4'($urandom), 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1001, 4'($urandom), 1'b0, 1'b0, 1'b0);
    checkOutput("ptr.third", int'(reqReadyA), 1);
    idleCycles(3);

    // Single requester with one-cycle latency, back to back.
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    idleCycles(1);
    for (int c = 0; c < 9; c++) begin
      applyStimulus(4'h0, 4'h0, 1'b1, 1'($urandom), 1'b0);
      if (c % 3 == 0) checkOutput("bound.req_ready", int'(reqReadyB), 1);
      if (c % 3 == 2) checkOutput("bound.rsp_valid", int'(rspValidB), 1);
      checkOutput("bound.grant_id", int'(grantIdB), 0);
    end
    idleCycles(3);

    // Reset in the first execution cycle drops the transaction.
    applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput("rstmid.accept", int'(reqReadyA), 4);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("rstmid.busy", int'(busyA), 0);
    checkOutput("rstmid.cpu_sig_i", int'(cpuSigIA), 0);
    checkOutput("rstmid.rsp_valid", int'(rspValidA), 0);
    checkOutput("rstmid.req_ready", int'(reqReadyA), 0);
    checkOutput("rstmid.grant_id", int'(grantIdA), 0);
    checkOutput("rstmid.check_count", int'(checkCountA), 0);
    idleCycles(3);
    applyStimulus(4'hF, 4'($urandom), 1'b0, 1'b0, 1'b0);
    checkOutput("rstmid.next", int'(reqReadyA), 1);
    idleCycles(3);

    // Check counter saturation over 300 checked transactions.
    coreMode = 1;
    for (int c = 0; c < 1200; c++) begin
      applyStimulus(4'hF, 4'($urandom), 1'b1, 1'($urandom), 1'b0);
      if (c % 4 == 3) checkOutput("cnt.rsp_check", int'(rspCheckA), 1);
    end
    idleCycles(1);
    checkOutput("cnt.saturateA", int'(checkCountA), 255);
    checkOutput("cnt.saturateB", int'(checkCountB), 255);
    coreMode = 2;
    applyStimulus(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0);
    idleCycles(2);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("cnt.zero_rsp_valid", int'(rspValidA), 2);
    checkOutput("cnt.zero_rsp_data", int'(rspDataA), 0);
    checkOutput("cnt.zero_rsp_check", int'(rspCheckA), 0);
    idleCycles(1);
    checkOutput("cnt.hold", int'(checkCountA), 255);

    // Randomized traffic with occasional resets.
    coreMode = 0;
    for (int c = 0; c < 400; c++) begin
      applyStimulus(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 39) == 0));
    end
    idleCycles(5);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
